// File: rtl/multdiv_ctrl_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  localparam int          STEP_COUNT = 32;

  // Two's-complement magnitude; INT_MIN maps to 2^31 read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Operand/start/result bundle between the execute stage and the mult/div unit.
interface multdiv_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_operandA;
  logic [DATA_WIDTH-1:0] data_operandB;
  logic                  ctrl_MULT;
  logic                  ctrl_DIV;
  logic [DATA_WIDTH-1:0] data_result;
  logic                  data_exception;
  logic                  data_resultRDY;
  logic                  data_busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, data_busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, data_busy
  );
endinterface

// File: rtl/multdiv_step.sv
// One combinational iteration of the shift-add multiply / restoring divide loop.
// Multiply: acc = {partial product, remaining multiplier bits}, operand = multiplicand.
// Divide:   acc = {remainder, dividend/quotient bits},          operand = divisor.
module multdiv_step
  import multdiv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   operand,
  input  op_t                     op,
  output logic [2*DATA_WIDTH-1:0] acc_next
);

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   rem_sh;
  logic [DATA_WIDTH-1:0] quo_sh;
  logic [DATA_WIDTH:0]   diff;

  // Single step; the extra sum bit keeps the carry of a 2^31 magnitude add.
  always_comb begin
    sum      = '0;
    rem_sh   = '0;
    quo_sh   = '0;
    diff     = '0;
    acc_next = acc;
    if (op == OP_MULT) begin
      sum      = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
               + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {sum, acc[DATA_WIDTH-1:1]};
    end else begin
      // remainder stays below the divisor, so the shifted value fits DATA_WIDTH+1 bits
      rem_sh = acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
      quo_sh = {acc[DATA_WIDTH-2:0], 1'b0};
      diff   = rem_sh - {1'b0, operand};
      if (!diff[DATA_WIDTH]) begin
        acc_next = {diff[DATA_WIDTH-1:0], quo_sh[DATA_WIDTH-1:1], 1'b1};
      end else begin
        acc_next = {rem_sh[DATA_WIDTH-1:0], quo_sh};
      end
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply/divide: sequencing FSM, magnitude/sign handling,
// 32-step loop via multdiv_step, then one sign-fix/exception cycle.
//
// state | meaning
// IDLE  | waiting for a start pulse, result held
// RUN   | one loop iteration per edge, 32 edges
// FIX   | sign fix + exception, registers result, pulses ready
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic            clock,
  input  logic            reset,
  multdiv_ctrl_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(STEP_COUNT - 1);

  state_t                  state_q, state_d;
  op_t                     op_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [2*DATA_WIDTH-1:0] acc_q, acc_next;
  logic [DATA_WIDTH-1:0]   mag_a_q, mag_b_q;
  logic [DATA_WIDTH-1:0]   raw_a_q, raw_b_q;
  logic                    sign_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    exc_q;
  logic                    rdy_q;

  logic                    start;
  logic                    busy;
  logic                    do_step;
  logic                    do_fix;
  logic [DATA_WIDTH-1:0]   mag_a, mag_b;
  logic [DATA_WIDTH-1:0]   step_operand;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]   quo;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign mag_a = mag32(bus.data_operandA);
  assign mag_b = mag32(bus.data_operandB);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: any start pulse (re)starts the loop from any state.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = (cnt_q == LAST_STEP) ? FIX : RUN;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs; a start pulse pre-empts stepping and fixing so aborts give no ready.
  always_comb begin
    busy    = (state_q != IDLE);
    do_step = (state_q == RUN) && !start;
    do_fix  = (state_q == FIX) && !start;
  end

  assign step_operand = (op_q == OP_MULT) ? mag_a_q : mag_b_q;

  multdiv_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .acc      (acc_q),
    .operand  (step_operand),
    .op       (op_q),
    .acc_next (acc_next)
  );

  // Sign fix of the loop outputs, used only in FIX.
  always_comb begin
    prod = sign_q ? (~acc_q + 1'b1) : acc_q;
    quo  = sign_q ? (~acc_q[DATA_WIDTH-1:0] + 1'b1) : acc_q[DATA_WIDTH-1:0];
  end

  // Operand capture, loop iteration and result registration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      acc_q    <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      raw_a_q  <= '0;
      raw_b_q  <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        op_q    <= bus.ctrl_MULT ? OP_MULT : OP_DIV;
        mag_a_q <= mag_a;
        mag_b_q <= mag_b;
        raw_a_q <= bus.data_operandA;
        raw_b_q <= bus.data_operandB;
        sign_q  <= bus.data_operandA[DATA_WIDTH-1] ^ bus.data_operandB[DATA_WIDTH-1];
        cnt_q   <= '0;
        // high half cleared; low half seeded with the multiplier or the dividend
        acc_q   <= {{DATA_WIDTH{1'b0}}, bus.ctrl_MULT ? mag_b : mag_a};
      end else if (do_step) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + 1'b1;
      end else if (do_fix) begin
        rdy_q <= 1'b1;
        if (op_q == OP_MULT) begin
          result_q <= prod[DATA_WIDTH-1:0];
          exc_q    <= (prod[2*DATA_WIDTH-1:DATA_WIDTH] != {DATA_WIDTH{prod[DATA_WIDTH-1]}});
        end else if (raw_b_q == '0) begin
          result_q <= '0;
          exc_q    <= 1'b1;
        end else if ((raw_a_q == INT_MIN) && (raw_b_q == '1)) begin
          result_q <= INT_MIN;
          exc_q    <= 1'b1;
        end else begin
          result_q <= quo;
          exc_q    <= 1'b0;
        end
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.data_busy      = busy;

endmodule
